rsa_cycle_meter_ctrl: RTL
=========================

# rsa_cycle_meter_ctrl

Measurement controller that sequences the shared free-running cycle counter to time RSA core operations. It arms on a software command, timestamps the core's start and done strobes against the counter value, and computes elapsed cycles with wrap-safe arithmetic. It keeps last/min/max statistics, a saturating sample count and sticky error/timeout flags, and owns the counter's clear line. It sits between the RSA core strobes, the cycle counter and the AXI4-Lite register file.

## Interface
- COUNTER_LENGTH, 128, width of counter input and all cycle-valued outputs
- SAMPLE_W, 16, width of sample counter
- CLOCK  in  1  system clock; all logic rising-edge
- RESET  in  1  synchronous, active-high
- COUNT  in  COUNTER_LENGTH  shared free-running counter value, +1 per cycle
- CNT_CLR  out  1  drives counter reset; counter reads 0 the cycle after CNT_CLR is sampled high
- ARM  in  1  one-cycle command: begin measuring
- CONT  in  1  level; 1 = re-arm after each sample, 0 = single shot
- ABORT  in  1  one-cycle command: drop current measurement
- CLEAR  in  1  one-cycle command: clear statistics, flags and counter
- OP_START  in  1  one-cycle strobe from RSA core
- OP_DONE  in  1  one-cycle strobe from RSA core
- TIMEOUT_CYCLES  in  COUNTER_LENGTH  timeout limit; 0 disables
- STATE  out  2  00 IDLE, 01 ARMED, 10 RUNNING (11 never driven)
- BUSY  out  1  STATE != IDLE
- VALID  out  1  one-cycle pulse: new sample recorded
- LAST, MIN, MAX  out  COUNTER_LENGTH  statistics
- SAMPLES  out  SAMPLE_W  recorded-sample count, saturating
- TIMED_OUT, ERR  out  1  sticky flags

## Operation
- Reset values:
  - STATE IDLE.
  - CNT_CLR, VALID, TIMED_OUT and ERR are 0.
  - LAST 0, MIN all-ones, MAX 0, SAMPLES 0.
  - Internal start timestamp 0.
- Command priority, highest first: CLEAR > ABORT > ARM > core strobes.
- CLEAR, any state:
  - Go to IDLE.
  - LAST, MIN, MAX, SAMPLES, TIMED_OUT and ERR take their reset values.
  - CNT_CLR is high for exactly one cycle.
- ABORT: go to IDLE, discard the timestamp; statistics are unchanged.
- IDLE:
  - ARM -> ARMED.
  - OP_START or OP_DONE is ignored and does not set ERR.
- ARMED:
  - OP_START -> RUNNING; the start timestamp is the COUNT value in the OP_START cycle.
  - OP_START and OP_DONE in the same cycle records a sample with elapsed 0.
  - OP_DONE alone sets ERR and stays ARMED.
- RUNNING:
  - OP_DONE records a sample with elapsed = (COUNT − start) mod 2^COUNTER_LENGTH, so a counter wrap still gives the correct result.
  - After a sample, go to ARMED if CONT=1, else IDLE.
  - OP_START sets ERR, restarts the timestamp and stays RUNNING.
- Timeout: in RUNNING with TIMEOUT_CYCLES != 0 and elapsed ≥ TIMEOUT_CYCLES (elapsed computed as above), TIMED_OUT is set, no sample is recorded, and the state goes to IDLE regardless of CONT.
- If OP_DONE arrives in the same cycle as the timeout, OP_DONE wins: the sample is recorded and TIMED_OUT is not set.
- Recording a sample:
  - LAST ← elapsed.
  - MIN ← min(MIN, elapsed); MAX ← max(MAX, elapsed). Comparisons are unsigned.
  - SAMPLES increments and saturates at all-ones.
  - VALID pulses.
- ARM while ARMED or RUNNING is ignored.

## Timing
- OP_DONE sampled at edge t: LAST, MIN, MAX and SAMPLES are updated, and VALID is high, in the cycle after edge t. VALID lasts exactly 1 cycle.
- With CONT=1, OP_START is accepted in the cycle after the sample edge.
- OP_START at edge t: STATE reads RUNNING after edge t.
- CLEAR at edge t: CNT_CLR is high in cycle t+1, COUNT reads 0 in cycle t+2, and statistics read their reset values from t+1.
- Timeout is evaluated every RUNNING cycle and takes effect at the edge where the condition is sampled true. There is no extra latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- RESET mid-measurement forces all reset values at the next edge. CNT_CLR is not asserted by RESET; the counter has its own reset.

## Test plan
- Basic sample:
  - Stimulus: ARM; OP_START at COUNT=100; OP_DONE at COUNT=350; CONT=0.
  - Required: LAST=MIN=MAX=250, SAMPLES=1, one VALID pulse, STATE IDLE.
- Continuous statistics:
  - Stimulus: CONT=1; three operations of 40, 10 and 25 cycles.
  - Required: LAST=25, MIN=10, MAX=40, SAMPLES=3, STATE ARMED.
- Wrap-around:
  - Stimulus: OP_START at COUNT=2^128−5; OP_DONE at COUNT=7.
  - Required: LAST=12.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=20; OP_START with no OP_DONE.
  - Required: TIMED_OUT=1 when elapsed reaches 20, STATE IDLE, SAMPLES unchanged.
- Timeout tie:
  - Stimulus: OP_DONE exactly when elapsed reaches 20.
  - Required: sample 20 recorded, TIMED_OUT=0.
- Errors and clear:
  - Stimulus: OP_DONE while ARMED, then a double OP_START; then CLEAR.
  - Required: ERR=1 after the errors. After CLEAR: ERR=0, MIN all-ones, SAMPLES=0, and CNT_CLR high for 1 cycle.

Source files
------------

// File: rtl/rsa_cycle_meter_ctrl_if.sv
// Signal bundle between the cycle meter controller, the RSA core strobes,
// the shared cycle counter and the register file.
interface rsa_cycle_meter_ctrl_if #(
   parameter int unsigned COUNTER_LENGTH = 128,
   parameter int unsigned SAMPLE_W       = 16
);
   logic [COUNTER_LENGTH-1:0] COUNT;
   logic                      CNT_CLR;
   logic                      ARM;
   logic                      CONT;
   logic                      ABORT;
   logic                      CLEAR;
   logic                      OP_START;
   logic                      OP_DONE;
   logic [COUNTER_LENGTH-1:0] TIMEOUT_CYCLES;
   logic [1:0]                STATE;
   logic                      BUSY;
   logic                      VALID;
   logic [COUNTER_LENGTH-1:0] LAST;
   logic [COUNTER_LENGTH-1:0] MIN;
   logic [COUNTER_LENGTH-1:0] MAX;
   logic [SAMPLE_W-1:0]       SAMPLES;
   logic                      TIMED_OUT;
   logic                      ERR;

   // Environment side: software commands, core strobes, counter value.
   modport master (
      output COUNT, ARM, CONT, ABORT, CLEAR, OP_START, OP_DONE, TIMEOUT_CYCLES,
      input  CNT_CLR, STATE, BUSY, VALID, LAST, MIN, MAX, SAMPLES, TIMED_OUT, ERR
   );

   // Controller side.
   modport slave (
      input  COUNT, ARM, CONT, ABORT, CLEAR, OP_START, OP_DONE, TIMEOUT_CYCLES,
      output CNT_CLR, STATE, BUSY, VALID, LAST, MIN, MAX, SAMPLES, TIMED_OUT, ERR
   );
endinterface

// File: rtl/rsa_cycle_meter_ctrl.sv
// Cycle meter controller: timestamps RSA core start/done strobes against the
// shared free-running counter and keeps last/min/max/count statistics.
module rsa_cycle_meter_ctrl #(
   parameter int unsigned COUNTER_LENGTH = 128,
   parameter int unsigned SAMPLE_W       = 16
) (
   input logic                   CLOCK,
   input logic                   RESET,
   rsa_cycle_meter_ctrl_if.slave bus
);

   localparam int unsigned CW = COUNTER_LENGTH;
   localparam int unsigned SW = SAMPLE_W;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      RUNNING = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   start_q, start_d;
   logic [CW-1:0]   last_q, last_d;
   logic [CW-1:0]   min_q, min_d;
   logic [CW-1:0]   max_q, max_d;
   logic [SW-1:0]   samples_q, samples_d;
   logic            timed_out_q, timed_out_d;
   logic            err_q, err_d;
   logic            valid_q, valid_d;
   logic            cnt_clr_q, cnt_clr_d;
   logic            busy_q, busy_d;

   logic [CW-1:0]   elapsed_c;
   logic            timeout_hit_c;
   logic            rec_c;
   logic [CW-1:0]   rec_val_c;

   // Modular subtraction keeps the result correct across a counter wrap.
   assign elapsed_c     = bus.COUNT - start_q;
   assign timeout_hit_c = (bus.TIMEOUT_CYCLES != '0) && (elapsed_c >= bus.TIMEOUT_CYCLES);

   // State and statistics registers.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= IDLE;
         start_q     <= '0;
         last_q      <= '0;
         min_q       <= '1;
         max_q       <= '0;
         samples_q   <= '0;
         timed_out_q <= 1'b0;
         err_q       <= 1'b0;
         valid_q     <= 1'b0;
         cnt_clr_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         last_q      <= last_d;
         min_q       <= min_d;
         max_q       <= max_d;
         samples_q   <= samples_d;
         timed_out_q <= timed_out_d;
         err_q       <= err_d;
         valid_q     <= valid_d;
         cnt_clr_q   <= cnt_clr_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state, command priority and sample recording.
   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      last_d      = last_q;
      min_d       = min_q;
      max_d       = max_q;
      samples_d   = samples_q;
      timed_out_d = timed_out_q;
      err_d       = err_q;
      valid_d     = 1'b0;
      cnt_clr_d   = 1'b0;
      rec_c       = 1'b0;
      rec_val_c   = '0;

      if (bus.CLEAR) begin
         state_d     = IDLE;
         start_d     = '0;
         last_d      = '0;
         min_d       = '1;
         max_d       = '0;
         samples_d   = '0;
         timed_out_d = 1'b0;
         err_d       = 1'b0;
         cnt_clr_d   = 1'b1;
      end else if (bus.ABORT) begin
         state_d = IDLE;
         start_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.ARM) state_d = ARMED;
            end
            ARMED: begin
               if (bus.OP_START && bus.OP_DONE) begin
                  rec_c     = 1'b1;
                  rec_val_c = '0;
               end else if (bus.OP_START) begin
                  state_d = RUNNING;
                  start_d = bus.COUNT;
               end else if (bus.OP_DONE) begin
                  err_d = 1'b1;
               end
            end
            RUNNING: begin
               if (bus.OP_DONE) begin
                  rec_c     = 1'b1;
                  rec_val_c = elapsed_c;
                  if (bus.OP_START) err_d = 1'b1;
               end else if (bus.OP_START) begin
                  err_d   = 1'b1;
                  start_d = bus.COUNT;
               end else if (timeout_hit_c) begin
                  timed_out_d = 1'b1;
                  state_d     = IDLE;
                  start_d     = '0;
               end
            end
            default: state_d = IDLE;
         endcase

         if (rec_c) begin
            last_d  = rec_val_c;
            valid_d = 1'b1;
            if (rec_val_c < min_q) min_d = rec_val_c;
            if (rec_val_c > max_q) max_d = rec_val_c;
            if (samples_q != '1) samples_d = samples_q + SW'(1);
            state_d = bus.CONT ? ARMED : IDLE;
         end
      end

      busy_d = (state_d != IDLE);
   end

   assign bus.STATE     = state_q;
   assign bus.BUSY      = busy_q;
   assign bus.VALID     = valid_q;
   assign bus.CNT_CLR   = cnt_clr_q;
   assign bus.LAST      = last_q;
   assign bus.MIN       = min_q;
   assign bus.MAX       = max_q;
   assign bus.SAMPLES   = samples_q;
   assign bus.TIMED_OUT = timed_out_q;
   assign bus.ERR       = err_q;

endmodule
